// File: rtl/mem_store_buffer_pkg.sv
// Shared types for the memory-stage store buffer: FSM states and the buffered store entry.
package mem_stage_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    LOAD_DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } store_entry_t;

endpackage

// File: rtl/mem_store_buffer_if.sv
// Request/response bundle between the EX/MEM register (master) and the store buffer (slave).
interface mem_store_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ex_valid;
  logic              ex_read;
  logic              ex_write;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_wdata;
  logic              ex_ready;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output ex_valid, ex_read, ex_write, ex_addr, ex_wdata,
    input  ex_ready, wb_valid, wb_data
  );

  modport slave (
    input  ex_valid, ex_read, ex_write, ex_addr, ex_wdata,
    output ex_ready, wb_valid, wb_data
  );
endinterface

// File: rtl/mem_store_buffer_fifo.sv
// Circular store buffer; with STORE_FORWARD_EN it also exposes every entry in age order
// (index 0 = oldest) for the load-forwarding search.
module store_fifo
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  store_entry_t           push_entry,
  output store_entry_t           head,
`ifdef STORE_FORWARD_EN
  output store_entry_t           age_entry [DEPTH],
  output logic [DEPTH-1:0]       age_valid,
`endif
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  store_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

`ifdef STORE_FORWARD_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_entry[i] = mem_q[rd_ptr_q + PTR_W'(i)];
      age_valid[i] = (CNT_W'(i) < count_q);
    end
  end
`endif

endmodule

// File: rtl/mem_store_buffer.sv
// Memory-stage front end: buffers stores, drains them one per cycle, serves loads.
// Optional macro STORE_FORWARD_EN enables load forwarding from buffered stores.
//
// state     | meaning
// IDLE      | accepting requests, draining buffered stores
// LOAD_WAIT | load miss in flight, Mem_read held for READ_LAT cycles
// LOAD_DONE | Read_Data returned to writeback, one-cycle wb_valid
module mem_store_buffer
  import mem_stage_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MEM_WORDS = 10,
  parameter int READ_LAT  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_store_buffer_if.slave      ex_if,
  output logic                   Mem_read,
  output logic                   Mem_write,
  output logic [ADDR_W-1:0]      Mem_address,
  output logic [DATA_W-1:0]      Write_data,
  input  logic [DATA_W-1:0]      Read_Data,
  output logic                   addr_err,
  output logic [$clog2(DEPTH):0] buf_count
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  mem_state_e        state_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic [ADDR_W-1:0] ld_addr_q;
  logic              wb_valid_q;
  logic [DATA_W-1:0] wb_data_q;

  logic [CNT_W-1:0]  count;
  store_entry_t      head;
  store_entry_t      push_entry;
  logic              idle, full, in_range, is_store, is_load;
  logic              load_ok, ready, accept, push, pop;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              miss_accept, hit_accept, oor_load, oor_any;

  assign idle     = (state_q == IDLE);
  assign full     = (count == CNT_W'(DEPTH));
  assign in_range = (ex_if.ex_addr < ADDR_W'(MEM_WORDS));
  // read+write together is treated as a store
  assign is_store = ex_if.ex_write;
  assign is_load  = ex_if.ex_read & ~ex_if.ex_write;

`ifdef STORE_FORWARD_EN
  store_entry_t     age_entry [DEPTH];
  logic [DEPTH-1:0] age_valid;

  // later (younger) matches overwrite earlier ones
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_valid[i] && (age_entry[i].addr == ex_if.ex_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = age_entry[i].data;
      end
    end
  end

  assign load_ok = idle;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  // without forwarding a load must see an empty buffer so memory is current
  assign load_ok  = idle & (count == '0);
`endif

  always_comb begin
    ready = idle & ~full;
    if (is_load) ready = load_ok;
  end

  assign ex_if.ex_ready = ready;
  assign accept      = ex_if.ex_valid & ready;
  assign push        = accept & is_store & in_range;
  assign miss_accept = accept & is_load & in_range & ~fwd_hit;
  assign hit_accept  = accept & is_load & in_range & fwd_hit;
  assign oor_load    = accept & is_load & ~in_range;
  assign oor_any     = accept & (is_load | is_store) & ~in_range;
  // a load miss takes the memory port this cycle, so the drain waits
  assign pop         = idle & (count != '0) & ~miss_accept;

  assign push_entry = '{addr: ex_if.ex_addr, data: ex_if.ex_wdata};

  store_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .head       (head),
`ifdef STORE_FORWARD_EN
    .age_entry  (age_entry),
    .age_valid  (age_valid),
`endif
    .count      (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      ld_addr_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      addr_err   <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      if (oor_any) addr_err <= 1'b1;
      case (state_q)
        IDLE: begin
          if (miss_accept) begin
            state_q   <= LOAD_WAIT;
            lat_cnt_q <= LAT_W'(READ_LAT - 1);
            ld_addr_q <= ex_if.ex_addr;
          end else if (hit_accept) begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= fwd_data;
          end else if (oor_load) begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= '0;
          end
        end
        LOAD_WAIT: begin
          if (lat_cnt_q == '0) state_q <= LOAD_DONE;
          else                 lat_cnt_q <= lat_cnt_q - LAT_W'(1);
        end
        LOAD_DONE: begin
          state_q   <= IDLE;
          wb_data_q <= Read_Data;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // miss data arrives during LOAD_DONE and is passed straight through
  assign ex_if.wb_valid = wb_valid_q | (state_q == LOAD_DONE);
  assign ex_if.wb_data  = (state_q == LOAD_DONE) ? Read_Data : wb_data_q;

  assign Mem_read    = (state_q == LOAD_WAIT);
  assign Mem_write   = pop;
  assign Mem_address = Mem_read ? ld_addr_q : (pop ? head.addr : '0);
  assign Write_data  = pop ? head.data : '0;
  assign buf_count   = count;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer: cycle table plus forwarding, stall and reset sequences.
module tb_mem_store_buffer;

  logic        clk;
  logic        reset;
  logic        Mem_read, Mem_write, addr_err;
  logic [31:0] Mem_address, Write_data, Read_Data;
  logic [2:0]  buf_count;

  mem_store_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_store_buffer #(
    .DEPTH(4), .DATA_W(32), .ADDR_W(32), .MEM_WORDS(10), .READ_LAT(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_if       (bus),
    .Mem_read    (Mem_read),
    .Mem_write   (Mem_write),
    .Mem_address (Mem_address),
    .Write_data  (Write_data),
    .Read_Data   (Read_Data),
    .addr_err    (addr_err),
    .buf_count   (buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef STORE_FORWARD_EN
  localparam int EXP_STALL = 0;
  localparam int EXP_LAT   = 1;
  localparam int EXP_MR    = 0;
  localparam int EXP_WAIT_CNT = 1;
`else
  localparam int EXP_STALL = 1;
  localparam int EXP_LAT   = 3;
  localparam int EXP_MR    = 2;
  localparam int EXP_WAIT_CNT = 0;
`endif

  // DataMemory model: writes at the edge, read data registered while Mem_read is high
  logic [31:0] mem [16];
  logic [31:0] rd_q;
  logic [31:0] wlog_a [$];
  logic [31:0] wlog_d [$];
  int          mr_cnt = 0;

  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
      rd_q <= 32'h0;
    end else begin
      if (Mem_write === 1'b1) begin
        mem[Mem_address[3:0]] <= Write_data;
        wlog_a.push_back(Mem_address);
        wlog_d.push_back(Write_data);
      end
      if (Mem_read === 1'b1) rd_q <= mem[Mem_address[3:0]];
    end
  end
  assign Read_Data = rd_q;

  always @(negedge clk) if (Mem_read === 1'b1) mr_cnt++;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v, rd, wr;
    logic [31:0] addr, wdata;
    logic        rdy, mw;
    logic [31:0] ma, wd;
    logic        mr, wbv;
    logic [31:0] wbd;
    logic [2:0]  cnt;
    logic        err;
  } vec_t;

  function automatic vec_t mk(logic v, logic rd, logic wr, logic [31:0] a, logic [31:0] d,
                              logic rdy, logic mw, logic [31:0] ma, logic [31:0] wd,
                              logic mr, logic wbv, logic [31:0] wbd, logic [2:0] cnt, logic err);
    vec_t r;
    r.v = v; r.rd = rd; r.wr = wr; r.addr = a; r.wdata = d;
    r.rdy = rdy; r.mw = mw; r.ma = ma; r.wd = wd;
    r.mr = mr; r.wbv = wbv; r.wbd = wbd; r.cnt = cnt; r.err = err;
    return r;
  endfunction

  localparam int NV = 23;
  vec_t tbl [NV];

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, output int stall);
    stall = 0;
    bus.ex_valid = 1'b1; bus.ex_read = rd; bus.ex_write = wr;
    bus.ex_addr = a; bus.ex_wdata = d;
    @(negedge clk);
    while (bus.ex_ready !== 1'b1 && stall < 20) begin
      stall++;
      @(negedge clk);
    end
    if (bus.ex_ready !== 1'b1) chk("issue_timeout", 32'(bus.ex_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0; bus.ex_read = 1'b0; bus.ex_write = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, lat, mr0, wn;

    //         v  rd wr addr   wdata    rdy mw ma     wd       mr wbv wbd    cnt err
    tbl[0]  = mk(0, 0, 0, 0,     0,       1, 0, 0,     0,       0, 0, 0,     0, 0);
    tbl[1]  = mk(1, 0, 1, 3,     32'hA,   1, 0, 0,     0,       0, 0, 0,     0, 0);
    tbl[2]  = mk(1, 0, 1, 5,     32'hB,   1, 1, 3,     32'hA,   0, 0, 0,     1, 0);
    tbl[3]  = mk(0, 0, 0, 0,     0,       1, 1, 5,     32'hB,   0, 0, 0,     1, 0);
    tbl[4]  = mk(0, 0, 0, 0,     0,       1, 0, 0,     0,       0, 0, 0,     0, 0);
    tbl[5]  = mk(1, 1, 0, 7,     0,       1, 0, 0,     0,       0, 0, 0,     0, 0);
    tbl[6]  = mk(0, 0, 0, 0,     0,       0, 0, 7,     0,       1, 0, 0,     0, 0);
    tbl[7]  = mk(0, 0, 0, 0,     0,       0, 0, 7,     0,       1, 0, 0,     0, 0);
    tbl[8]  = mk(0, 0, 0, 0,     0,       0, 0, 0,     0,       0, 1, 0,     0, 0);
    tbl[9]  = mk(1, 1, 0, 3,     0,       1, 0, 0,     0,       0, 0, 0,     0, 0);
    tbl[10] = mk(0, 0, 0, 0,     0,       0, 0, 3,     0,       1, 0, 0,     0, 0);
    tbl[11] = mk(0, 0, 0, 0,     0,       0, 0, 3,     0,       1, 0, 0,     0, 0);
    tbl[12] = mk(0, 0, 0, 0,     0,       0, 0, 0,     0,       0, 1, 32'hA, 0, 0);
    tbl[13] = mk(1, 0, 1, 12,    32'h55,  1, 0, 0,     0,       0, 0, 0,     0, 0);
    tbl[14] = mk(1, 1, 0, 12,    0,       1, 0, 0,     0,       0, 0, 0,     0, 1);
    tbl[15] = mk(0, 0, 0, 0,     0,       1, 0, 0,     0,       0, 1, 0,     0, 1);
    tbl[16] = mk(1, 0, 1, 9,     32'h99,  1, 0, 0,     0,       0, 0, 0,     0, 1);
    tbl[17] = mk(0, 0, 0, 0,     0,       1, 1, 9,     32'h99,  0, 0, 0,     1, 1);
    tbl[18] = mk(0, 0, 0, 0,     0,       1, 0, 0,     0,       0, 0, 0,     0, 1);
    tbl[19] = mk(1, 1, 1, 4,     32'h44,  1, 0, 0,     0,       0, 0, 0,     0, 1);
    tbl[20] = mk(0, 0, 0, 0,     0,       1, 1, 4,     32'h44,  0, 0, 0,     1, 1);
    tbl[21] = mk(0, 0, 1, 6,     32'h66,  1, 0, 0,     0,       0, 0, 0,     0, 1);
    tbl[22] = mk(0, 0, 0, 0,     0,       1, 0, 0,     0,       0, 0, 0,     0, 1);

    reset = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_read = 1'b0; bus.ex_write = 1'b0;
    bus.ex_addr = '0; bus.ex_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",     32'(bus.ex_ready), 32'd1);
    chk("rst_mem_read",  32'(Mem_read),     32'd0);
    chk("rst_mem_write", 32'(Mem_write),    32'd0);
    chk("rst_mem_addr",  Mem_address,       32'd0);
    chk("rst_wb_valid",  32'(bus.wb_valid), 32'd0);
    chk("rst_count",     32'(buf_count),    32'd0);
    chk("rst_addr_err",  32'(addr_err),     32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      bus.ex_valid = tbl[i].v; bus.ex_read = tbl[i].rd; bus.ex_write = tbl[i].wr;
      bus.ex_addr = tbl[i].addr; bus.ex_wdata = tbl[i].wdata;
      @(negedge clk);
      chk($sformatf("r%0d_ready", i),    32'(bus.ex_ready), 32'(tbl[i].rdy));
      chk($sformatf("r%0d_mem_write", i), 32'(Mem_write),   32'(tbl[i].mw));
      chk($sformatf("r%0d_mem_addr", i),  Mem_address,      tbl[i].ma);
      chk($sformatf("r%0d_wdata", i),     Write_data,       tbl[i].wd);
      chk($sformatf("r%0d_mem_read", i),  32'(Mem_read),    32'(tbl[i].mr));
      chk($sformatf("r%0d_wb_valid", i),  32'(bus.wb_valid), 32'(tbl[i].wbv));
      if (tbl[i].wbv) chk($sformatf("r%0d_wb_data", i), bus.wb_data, tbl[i].wbd);
      chk($sformatf("r%0d_count", i),     32'(buf_count),   32'(tbl[i].cnt));
      chk($sformatf("r%0d_addr_err", i),  32'(addr_err),    32'(tbl[i].err));
      @(posedge clk);
      #1;
    end
    bus.ex_valid = 1'b0; bus.ex_read = 1'b0; bus.ex_write = 1'b0;

    // two stores to the same word, then a load of it
    issue(1'b0, 1'b1, 32'd2, 32'h11, st);
    issue(1'b0, 1'b1, 32'd2, 32'h22, st);
    mr0 = mr_cnt;
    issue(1'b1, 1'b0, 32'd2, 32'h0, st);
    chk("fwd_stall", 32'(st), 32'(EXP_STALL));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.wb_valid !== 1'b1 && lat < 10);
    chk("fwd_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("fwd_wb_data",  bus.wb_data,       32'h22);
    chk("fwd_latency",  32'(lat),          32'(EXP_LAT));
    chk("fwd_mem_reads", 32'(mr_cnt - mr0), 32'(EXP_MR));
    @(posedge clk);
    #1;

    // stores around a load miss: stall while the load owns the port, order kept
    idle_cycles(3);
    wlog_a.delete();
    wlog_d.delete();
    issue(1'b0, 1'b1, 32'd0, 32'h100, st);
    issue(1'b0, 1'b1, 32'd1, 32'h101, st);
    issue(1'b1, 1'b0, 32'd8, 32'h0, st);
    chk("blk_load_stall", 32'(st), 32'(EXP_STALL));
    issue(1'b0, 1'b1, 32'd2, 32'h102, st);
    chk("blk_store_stall", 32'(st), 32'd3);
    issue(1'b0, 1'b1, 32'd3, 32'h103, st);
    chk("blk_store3_stall", 32'(st), 32'd0);
    issue(1'b0, 1'b1, 32'd4, 32'h104, st);
    idle_cycles(6);
    chk("blk_write_count", 32'(wlog_a.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < wlog_a.size()) begin
        chk($sformatf("blk_w%0d_addr", i), wlog_a[i], 32'(i));
        chk($sformatf("blk_w%0d_data", i), wlog_d[i], 32'h100 + 32'(i));
      end
    end
    chk("blk_count_end", 32'(buf_count), 32'd0);

    // asynchronous reset in the middle of a load miss
    issue(1'b0, 1'b1, 32'd6, 32'h66, st);
    issue(1'b1, 1'b0, 32'd7, 32'h0, st);
    @(negedge clk);
    chk("rl_mem_read_before", 32'(Mem_read),  32'd1);
    chk("rl_count_before",    32'(buf_count), 32'(EXP_WAIT_CNT));
    chk("rl_err_before",      32'(addr_err),  32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rl_mem_read",  32'(Mem_read),     32'd0);
    chk("rl_mem_addr",  Mem_address,       32'd0);
    chk("rl_count",     32'(buf_count),    32'd0);
    chk("rl_ready",     32'(bus.ex_ready), 32'd1);
    chk("rl_addr_err",  32'(addr_err),     32'd0);
    chk("rl_wb_valid",  32'(bus.wb_valid), 32'd0);
    mr0 = mr_cnt;
    wn = wlog_a.size();
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(6);
    chk("rl_no_write_after", 32'(wlog_a.size()), 32'(wn));
    chk("rl_no_read_after",  32'(mr_cnt),        32'(mr0));
    chk("rl_count_after",    32'(buf_count),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
